// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan receiver: glyph table, FSM states, digit index.
// SEG_SCAN_RX_BCD_EN restricts legal glyphs to 0..9.
package seg_pkg;

  typedef logic [1:0] dig_idx_t;

  typedef enum logic [1:0] {HUNT, COLLECT, CONFIRM} state_t;

  // Index k holds the a..g pattern for nibble k.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

`ifdef SEG_SCAN_RX_BCD_EN
  localparam int NGLYPH = 10;
`else
  localparam int NGLYPH = 16;
`endif

  function automatic logic [15:0] bcd_to_bin(input logic [15:0] d);
    return 16'(d[15:12]) * 16'd1000 + 16'(d[11:8]) * 16'd100 +
           16'(d[7:4]) * 16'd10 + 16'(d[3:0]);
  endfunction

endpackage

// File: rtl/seg_pat_dec.sv
// Combinational 7-segment pattern decoder: nibble plus legal flag.
// SEG_SCAN_RX_BCD_EN (via seg_pkg::NGLYPH) makes glyphs A..F illegal.
module seg_pat_dec
  import seg_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_nib,
  output logic       o_legal
);

  always_comb begin
    o_nib   = 4'd0;
    o_legal = 1'b0;
    for (int k = 0; k < NGLYPH; k++) begin
      if (i_pat == GLYPH[k]) begin
        o_nib   = 4'(k);
        o_legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Receive side of a 4-digit multiplexed 7-segment scan: reassembles frames, confirms
// them after STABLE_FRAMES repeats, flags bad glyphs/order and link timeout.
// SEG_SCAN_RX_BCD_EN publishes the decimal value of a 0..9999 frame instead of raw nibbles.
module seg_scan_rx
  import seg_pkg::*;
#(
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT       = 16
) (
  input  logic        ms_clock,
  input  logic        reset,
  input  logic [1:0]  port,
  input  logic [7:0]  pattern,
  output logic [15:0] number,
  output logic        number_valid,
  output logic        changed,
  output logic        seg_err,
  output logic        seq_err,
  output logic        stale
);

  dig_idx_t    r_port, r_last_port;
  logic [6:0]  r_pat;
  logic        w_samp;
  logic [3:0]  w_nib;
  logic        w_legal;
  logic        w_unused_dp;

  logic        r_s_vld, r_s_legal;
  dig_idx_t    r_s_idx;
  logic [3:0]  r_s_nib;

  logic [15:0] r_idle;
  logic        w_to;

  state_t      r_state;
  dig_idx_t    r_exp, w_exp;
  logic [11:0] r_col;
  logic [15:0] r_frame, r_prev, w_val;
  logic [3:0]  r_stable, w_stab_nx;

  assign w_unused_dp = pattern[7];
  // A sample is one port transition, so slow scans yield one sample per digit.
  assign w_samp      = (r_port != r_last_port);

  seg_pat_dec u_dec (.i_pat(r_pat), .o_nib(w_nib), .o_legal(w_legal));

  always_ff @(posedge ms_clock) begin
    if (reset) begin
      r_port      <= 2'd3;
      r_last_port <= 2'd3;
      r_pat       <= '0;
      r_s_vld     <= 1'b0;
      r_s_legal   <= 1'b0;
      r_s_idx     <= '0;
      r_s_nib     <= '0;
    end else begin
      r_port    <= port;
      r_pat     <= pattern[6:0];
      r_s_vld   <= w_samp;
      r_s_legal <= w_legal;
      r_s_idx   <= r_port;
      r_s_nib   <= w_nib;
      if (w_samp) r_last_port <= r_port;
    end
  end

  always_ff @(posedge ms_clock) begin
    if (reset)                          r_idle <= '0;
    else if (w_samp)                    r_idle <= '0;
    else if (r_idle != 16'(TIMEOUT))    r_idle <= r_idle + 16'd1;
  end

  assign w_to = !w_samp && (r_idle == 16'(TIMEOUT - 1));

  always_comb begin
    w_exp     = (r_state == CONFIRM) ? 2'd0 : r_exp;
    w_stab_nx = (r_frame != r_prev) ? 4'd1 :
                (r_stable == 4'(STABLE_FRAMES)) ? r_stable : r_stable + 4'd1;
`ifdef SEG_SCAN_RX_BCD_EN
    w_val     = bcd_to_bin(r_frame);
`else
    w_val     = r_frame;
`endif
  end

  always_ff @(posedge ms_clock) begin
    if (reset) begin
      r_state      <= HUNT;
      r_exp        <= '0;
      r_col        <= '0;
      r_frame      <= '0;
      r_prev       <= '0;
      r_stable     <= '0;
      number       <= '0;
      number_valid <= 1'b0;
      changed      <= 1'b0;
      seg_err      <= 1'b0;
      seq_err      <= 1'b0;
      stale        <= 1'b0;
    end else begin
      number_valid <= 1'b0;
      changed      <= 1'b0;
      seg_err      <= 1'b0;
      seq_err      <= 1'b0;
      if (w_to) begin
        stale    <= 1'b1;
        r_state  <= HUNT;
        r_stable <= '0;
        r_col    <= '0;
      end else begin
        if (r_state == CONFIRM) begin
          r_stable <= w_stab_nx;
          r_prev   <= r_frame;
          r_state  <= COLLECT;
          r_exp    <= 2'd0;
          if (w_stab_nx == 4'(STABLE_FRAMES)) begin
            number       <= w_val;
            number_valid <= 1'b1;
            changed      <= (w_val != number);
            stale        <= 1'b0;
          end
        end
        // A sample landing in CONFIRM is handled here as the first digit of the next frame.
        if (r_s_vld) begin
          if (!r_s_legal) begin
            seg_err  <= 1'b1;
            r_col    <= '0;
            r_stable <= '0;
            r_state  <= HUNT;
          end else begin
            case (r_state)
              HUNT: begin
                if (r_s_idx == 2'd0) begin
                  r_col   <= {8'h0, r_s_nib};
                  r_exp   <= 2'd1;
                  r_state <= COLLECT;
                end
              end
              COLLECT, CONFIRM: begin
                if (r_s_idx == w_exp) begin
                  case (r_s_idx)
                    2'd0: r_col <= {8'h0, r_s_nib};
                    2'd1: r_col[7:4]  <= r_s_nib;
                    2'd2: r_col[11:8] <= r_s_nib;
                    default: r_frame <= {r_s_nib, r_col};
                  endcase
                  r_exp   <= r_s_idx + 2'd1;
                  r_state <= (r_s_idx == 2'd3) ? CONFIRM : COLLECT;
                end else begin
                  seq_err <= 1'b1;
                  if (r_s_idx == 2'd0) begin
                    r_col   <= {8'h0, r_s_nib};
                    r_exp   <= 2'd1;
                    r_state <= COLLECT;
                  end else begin
                    r_col   <= '0;
                    r_state <= HUNT;
                  end
                end
              end
              default: r_state <= HUNT;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_rx.sv
// Scoreboard bench for seg_scan_rx: an event-level model predicts confirmations and error
// pulses from the sample stream; a negedge monitor checks them as the DUT emits them.
module tb_seg_scan_rx;

  localparam int SF = 2;
  localparam int TO = 16;

  localparam bit [6:0] TG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam bit [6:0] ILL [3] = '{7'h00, 7'h01, 7'h7E};
`ifdef SEG_SCAN_RX_BCD_EN
  localparam int NG = 10;
`else
  localparam int NG = 16;
`endif

  logic        ms_clock = 1'b0;
  logic        reset;
  logic [1:0]  port;
  logic [7:0]  pattern;
  logic [15:0] number;
  logic        number_valid, changed, seg_err, seq_err, stale;

  seg_scan_rx #(.STABLE_FRAMES(SF), .TIMEOUT(TO)) dut (
    .ms_clock(ms_clock), .reset(reset), .port(port), .pattern(pattern),
    .number(number), .number_valid(number_valid), .changed(changed),
    .seg_err(seg_err), .seq_err(seq_err), .stale(stale)
  );

  always #5 ms_clock = ~ms_clock;

  typedef struct { int num; int chg; } ev_t;
  ev_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int exp_seg = 0, exp_seq = 0, got_seg = 0, got_seq = 0;
  int m_mode, m_exp, m_prev, m_stable, m_num, m_stale, b_last;
  int m_dig[4];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input int pat);
    for (int k = 0; k < NG; k++) if (pat == int'(TG[k])) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_prev = 0; m_stable = 0; m_num = 0; m_stale = 0; b_last = 3;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  // Frame-level reference: digits arrive in order 0..3, a frame is confirmed once it has
  // been seen SF times in a row.
  task automatic model_sample(input int idx, input int pat);
    int n, frame, val;
    n = dec(pat);
    if (n < 0) begin exp_seg++; m_mode = 0; m_stable = 0; return; end
    if (m_mode == 0) begin
      if (idx == 0) begin m_dig[0] = n; m_exp = 1; m_mode = 1; end
      return;
    end
    if (idx != m_exp) begin
      exp_seq++;
      if (idx == 0) begin m_dig[0] = n; m_exp = 1; end
      else m_mode = 0;
      return;
    end
    m_dig[idx] = n;
    if (idx < 3) begin m_exp++; return; end
    frame = m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0];
    if (frame == m_prev) m_stable = (m_stable < SF) ? m_stable + 1 : SF;
    else m_stable = 1;
    m_prev = frame;
    m_exp  = 0;
    if (m_stable == SF) begin
`ifdef SEG_SCAN_RX_BCD_EN
      val = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
`else
      val = frame;
`endif
      exp_q.push_back('{val, int'(val != m_num)});
      m_num   = val;
      m_stale = 0;
    end
  endtask

  always @(negedge ms_clock) begin
    if (reset === 1'b0) begin
      if (number_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", int'(number), -1);
        else begin
          ev_t e;
          e = exp_q.pop_front();
          check("number", int'(number), e.num);
          check("changed", int'(changed), e.chg);
        end
      end
      if (seg_err) got_seg++;
      if (seq_err) got_seq++;
    end
  end

  task automatic apply(input int idx, input logic [7:0] pat, input int hold);
    port = 2'(idx); pattern = pat;
    if (idx != b_last) begin model_sample(idx, int'(pat[6:0])); b_last = idx; end
    repeat (hold) @(posedge ms_clock);
    #1;
  endtask

  task automatic send_frame(input int val, input int hold);
    for (int i = 0; i < 4; i++) apply(i, {1'b0, TG[(val >> (4 * i)) & 15]}, hold);
  endtask

  task automatic checkpoint(input string tag);
    repeat (8) @(posedge ms_clock);
    #1;
    $display("checkpoint %s", tag);
    check("seg_err_count", got_seg, exp_seg);
    check("seq_err_count", got_seq, exp_seq);
    check("number_held", int'(number), m_num);
    check("stale", int'(stale), m_stale);
    check("pending_valid", exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_number"}, int'(number), 0);
    check({tag, "_pulses"}, int'({number_valid, changed, seg_err, seq_err}), 0);
    check({tag, "_stale"}, int'(stale), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; port = 2'd3; pattern = 8'h00;
    model_reset();
    repeat (2) @(posedge ms_clock);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    send_frame(16'h1234, 1);
    send_frame(16'h1234, 1);
    checkpoint("clean_1234");

    send_frame(16'h0A0F, 5);
    send_frame(16'h0A0F, 5);
    checkpoint("slow_0A0F");

    send_frame(16'h1111, 1);
    send_frame(16'h1111, 1);
    apply(0, {1'b0, TG[1]}, 1);
    apply(1, {1'b0, TG[1]}, 1);
    apply(2, 8'h00, 1);
    apply(3, {1'b0, TG[1]}, 1);
    checkpoint("corrupt_idx2");
    send_frame(16'h2222, 1);
    send_frame(16'h2222, 2);
    checkpoint("recover_2222");

    apply(0, {1'b0, TG[4]}, 1);
    apply(1, {1'b0, TG[4]}, 1);
    apply(3, {1'b0, TG[4]}, 1);
    send_frame(16'h4444, 1);
    send_frame(16'h4444, 1);
    checkpoint("order_skip");

    send_frame(16'h5678, 1);
    send_frame(16'h5678, 1);
    repeat (TO + 14) @(posedge ms_clock);
    #1;
    m_mode = 0; m_stable = 0; m_stale = 1;
    checkpoint("timeout");
    send_frame(16'h5678, 1);
    checkpoint("stale_one_frame");
    send_frame(16'h5678, 1);
    checkpoint("stale_cleared");

    apply(0, {1'b0, TG[3]}, 1);
    apply(1, {1'b0, TG[3]}, 1);
    reset = 1'b1; port = 2'd3;
    @(posedge ms_clock);
    #1;
    check_zero_outputs("mid_reset");
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    got_seg = 0; got_seq = 0; exp_seg = 0; exp_seq = 0;
    apply(2, {1'b0, TG[2]}, 1);
    apply(3, {1'b0, TG[2]}, 1);
    send_frame(16'h9ABC, 1);
    send_frame(16'h9ABC, 1);
    checkpoint("after_reset");

    for (int f = 0; f < 40; f++) begin
      int val, reps, skip;
      logic [7:0] pat;
      val  = int'($urandom_range(0, 65535));
      reps = int'($urandom_range(1, 3));
      for (int r = 0; r < reps; r++) begin
        skip = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
        for (int i = 0; i < 4; i++) begin
          if (i == skip) continue;
          pat = {1'($urandom), TG[(val >> (4 * i)) & 15]};
          if ($urandom_range(0, 11) == 0) pat[6:0] = ILL[$urandom_range(0, 2)];
          apply(i, pat, int'($urandom_range(1, 4)));
        end
      end
    end
    checkpoint("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_rx.md
Name: seg_scan_rx

Overview:
- Receive end of the multiplexed 4-digit 7-segment scan interface: samples the `port` digit-select and the `pattern` segment bus.
- Decodes each pattern back to a nibble and reassembles full 4-digit frames.
- Publishes a 16-bit number only after a configurable number of identical consecutive frames.
- Used for display loopback self-check and for monitoring an external scanned display.

Parameters:
- STABLE_FRAMES, 2: consecutive identical complete frames required before `number` updates (1..15).
- TIMEOUT, 16: `ms_clock` cycles without a `port` change before the link is declared stale (2..65535).

Ports:
- ms_clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- port  in  2  digit index currently driven; 0 = least-significant digit.
- pattern  in  8  segment bus; bit0..bit6 = segments a..g, active-high; bit7 = dp, ignored.
- number  out  16  confirmed value; {d3,d2,d1,d0}, d0 from port 0.
- number_valid  out  1  one-cycle pulse on every confirmed frame.
- changed  out  1  one-cycle pulse, coincident with `number_valid`, when the confirmed value differs from the previous `number`.
- seg_err  out  1  one-cycle pulse when a sampled pattern is not a legal glyph.
- seq_err  out  1  one-cycle pulse when the digit index breaks the order 0,1,2,3.
- stale  out  1  level; high while the link is timed out.

Behaviour:
- Reset: one clock is used throughout; reset is synchronous and active-high.
  - All of `number`, `number_valid`, `changed`, `seg_err`, `seq_err` clear to 0; `stale` clears to 0.
  - FSM goes to HUNT; stable counter = 0; frame buffers = 0; last_port = 3.
  - Reset mid-frame discards all partial data.
- Sampling:
  - Inputs are registered once; a sample is taken only when the registered `port` differs from last_port.
  - Oversampled slow scans are therefore tolerated.
  - Decode latency is 1 cycle from the port-change register stage to the decoded nibble.
- Glyph table (pattern[6:0] to nibble):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7
  - 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F
  - Any other value is illegal.
- FSM states HUNT, COLLECT, CONFIRM:
  - HUNT: wait for a sample with index 0. Store d0, expect index 1, go to COLLECT.
  - COLLECT, sample with the expected index: store the nibble and increment expected. After index 3, go to CONFIRM.
  - COLLECT, unexpected index: pulse `seq_err`, clear partial frame. If the index is 0, restart collection in place; otherwise go to HUNT.
  - CONFIRM (1 cycle): compare the frame to the previous complete frame.
    - Equal: stable counter increments, saturating at STABLE_FRAMES.
    - Different: stable counter = 1.
    - When the counter reaches STABLE_FRAMES: load `number`, pulse `number_valid`, and pulse `changed` if the new value differs.
    - Return to COLLECT expecting index 0. The next sample with index 0 starts a new frame; if that sample arrives during the CONFIRM cycle it is held one cycle, not lost.
- Illegal glyph, any state: pulse `seg_err`, discard the partial frame, stable counter = 0, go to HUNT.
- Simultaneous illegal glyph and out-of-order index: only `seg_err` pulses.
- Continued confirmation: after the first confirmation, each further identical frame re-pulses `number_valid` (counter stays saturated); `changed` stays 0.
- Timeout:
  - An idle counter resets on every sample. At TIMEOUT it sets `stale`, goes to HUNT, and stable counter = 0.
  - `number` holds its last confirmed value.
  - `stale` clears on the next complete confirmed frame.
- Counter widths: the idle counter saturates; it never wraps.

Optional Feature:
- Macro: SEG_SCAN_RX_BCD_EN.
- Defined:
  - Glyphs A–F are treated as illegal and raise `seg_err`.
  - `number` holds the binary value d3*1000 + d2*100 + d1*10 + d0, range 0..9999, computed in the CONFIRM cycle.
  - Latency and pulse timing are unchanged.
- Undefined: raw nibble packing as described above; A–F are legal.

Decomposition:
- Package seg_pkg:
  - 7-bit glyph constants for 0..F.
  - FSM state enum (HUNT, COLLECT, CONFIRM).
  - Digit index type (2 bits).
- Sub-module seg_pat_dec: combinational; 7-bit pattern in, 4-bit nibble plus legal flag out; BCD restriction selected by the same macro.
- Shared by future display blocks.

Test Plan:
- Clean scan, 1 sample per port, frame 0x1234 repeated, STABLE_FRAMES=2:
  - First `number_valid` and `changed` pulse in the CONFIRM cycle of frame 2; `number` = 0x1234.
  - With BCD enabled, `number` = 16'd1234.
- Slow scan, each port held 5 cycles, value 0x0A0F: identical result to the 1-cycle scan; no `seq_err`.
- Frame 0x1111 confirmed, then one corrupted pattern 0x00 on index 2:
  - `seg_err` pulse; `number` stays 0x1111.
  - Two clean 0x2222 frames then give `number_valid` and `changed` with 0x2222.
- Index order 0,1,3: `seq_err` on index 3; FSM in HUNT; next full 0..3 frame starts a new collection.
- Port frozen 16 cycles after a confirmed 0x5678:
  - `stale` rises at cycle 16; `number` = 0x5678 held.
  - `stale` clears after two valid frames.
- Reset asserted mid-COLLECT: all outputs 0 next cycle; only frames starting at index 0 after reset are accepted.
